// File: rtl/vs_hex_word_parser.sv
// vs_hex_word_parser
// Accumulates ASCII hex digits MSB-first into a W-bit word and hands the word
// to the command layer when a terminator (CR, LF, space) arrives.
//
// Ports:
//   CLK, RST        clock (rising edge), synchronous active-high reset
//   ASCII/_VLD/_RDY byte input handshake from the UART receive path
//   WORD, WORD_CNT  parsed word (right-aligned) and its digit count
//   WORD_VLD/_RDY   word output handshake
//   ERR, ERR_CODE   one-cycle error pulse; 01 invalid char, 10 overflow,
//                   11 empty prefix
//
// Optional feature macro: VS_HEX_PREFIX_EN
//   When defined, a leading "0x"/"0X" is accepted and not counted as digits.
//
// state   | meaning
// IDLE    | no digits collected, terminators ignored
// ACC     | collecting digits
// DISCARD | after an error, swallowing bytes until a terminator
// HOLD    | word presented, waiting for WORD_RDY
module vs_hex_word_parser #(
    parameter int DIGITS = 4,
    parameter int W      = 4 * DIGITS,
    parameter int CW     = $clog2(DIGITS + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [7:0]    ASCII,
    input  logic          ASCII_VLD,
    output logic          ASCII_RDY,
    output logic [W-1:0]  WORD,
    output logic [CW-1:0] WORD_CNT,
    output logic          WORD_VLD,
    input  logic          WORD_RDY,
    output logic          ERR,
    output logic [1:0]    ERR_CODE
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACC     = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;
    localparam logic [1:0] S_HOLD    = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  word_q, word_d;
    logic [CW-1:0] word_cnt_q, word_cnt_d;
    logic          word_vld_q, word_vld_d;
    logic          err_q, err_d;
    logic [1:0]    err_code_q, err_code_d;

    logic          is_dec, is_upper, is_lower, is_digit, is_term;
    logic [3:0]    dig_val;
    logic          accept;
    logic          take_pfx;   // byte is a legal "x" prefix right now
    logic          empty_pfx;  // terminator would close a prefix-only word

    assign is_dec   = (ASCII >= 8'h30) && (ASCII <= 8'h39);
    assign is_upper = (ASCII >= 8'h41) && (ASCII <= 8'h46);
    assign is_lower = (ASCII >= 8'h61) && (ASCII <= 8'h66);
    assign is_digit = is_dec || is_upper || is_lower;
    assign is_term  = (ASCII == 8'h0D) || (ASCII == 8'h0A) || (ASCII == 8'h20);
    // Letters: low nibble 1..6 maps to 10..15 for both cases.
    assign dig_val  = is_dec ? ASCII[3:0] : (ASCII[3:0] + 4'd9);

    assign accept   = ASCII_VLD && ASCII_RDY;

`ifdef VS_HEX_PREFIX_EN
    logic prefix_q, prefix_d;
    logic is_pfx;

    assign is_pfx    = (ASCII == 8'h78) || (ASCII == 8'h58);
    // The prefix is only legal right after a single leading '0'.
    assign take_pfx  = is_pfx && !prefix_q && (cnt_q == CW'(1)) && (acc_q == '0);
    assign empty_pfx = prefix_q && (cnt_q == '0);

    always_comb begin
        prefix_d = prefix_q;
        if ((state_q == S_ACC) && accept && take_pfx) begin
            prefix_d = 1'b1;
        end
        if (state_d != S_ACC) begin
            prefix_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            prefix_q <= 1'b0;
        end else begin
            prefix_q <= prefix_d;
        end
    end
`else
    assign take_pfx  = 1'b0;
    assign empty_pfx = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        word_cnt_d = word_cnt_q;
        word_vld_d = word_vld_q;
        err_d      = 1'b0;
        err_code_d = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_digit) begin
                        acc_d   = W'(dig_val);
                        cnt_d   = CW'(1);
                        state_d = S_ACC;
                    end else if (!is_term) begin
                        err_d      = 1'b1;
                        err_code_d = 2'b01;
                        state_d    = S_DISCARD;
                    end
                end
            end
            S_ACC: begin
                if (accept) begin
                    if (is_digit) begin
                        if (cnt_q == CW'(DIGITS)) begin
                            err_d      = 1'b1;
                            err_code_d = 2'b10;
                            acc_d      = '0;
                            cnt_d      = '0;
                            state_d    = S_DISCARD;
                        end else begin
                            acc_d = (acc_q << 4) | W'(dig_val);
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else if (is_term) begin
                        if (empty_pfx) begin
                            err_d      = 1'b1;
                            err_code_d = 2'b11;
                            acc_d      = '0;
                            cnt_d      = '0;
                            state_d    = S_IDLE;
                        end else begin
                            word_d     = acc_q;
                            word_cnt_d = cnt_q;
                            word_vld_d = 1'b1;
                            state_d    = S_HOLD;
                        end
                    end else if (take_pfx) begin
                        acc_d = '0;
                        cnt_d = '0;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = 2'b01;
                        acc_d      = '0;
                        cnt_d      = '0;
                        state_d    = S_DISCARD;
                    end
                end
            end
            S_DISCARD: begin
                if (accept && is_term) begin
                    state_d = S_IDLE;
                end
            end
            default: begin  // S_HOLD: ASCII_RDY is low, bytes are not taken
                if (word_vld_q && WORD_RDY) begin
                    word_vld_d = 1'b0;
                    acc_d      = '0;
                    cnt_d      = '0;
                    state_d    = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            word_q     <= '0;
            word_cnt_q <= '0;
            word_vld_q <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            word_cnt_q <= word_cnt_d;
            word_vld_q <= word_vld_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign ASCII_RDY = (state_q != S_HOLD);
    assign WORD      = word_q;
    assign WORD_CNT  = word_cnt_q;
    assign WORD_VLD  = word_vld_q;
    assign ERR       = err_q;
    assign ERR_CODE  = err_code_q;

endmodule

// File: tb/tb_vs_hex_word_parser.sv
// Testbench for vs_hex_word_parser (DIGITS=4): directed byte strings followed
// by a random byte stream, every cycle compared against a reference model
// that keeps the collected digits in a queue.
module tb_vs_hex_word_parser;

    localparam int DIGITS = 4;
    localparam int W      = 16;
    localparam int CW     = 3;
`ifdef VS_HEX_PREFIX_EN
    localparam bit PFX = 1'b1;
`else
    localparam bit PFX = 1'b0;
`endif
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;
    localparam logic [7:0] SP = 8'h20;

    logic          CLK = 1'b0;
    logic          RST;
    logic [7:0]    ASCII;
    logic          ASCII_VLD;
    logic          ASCII_RDY;
    logic [W-1:0]  WORD;
    logic [CW-1:0] WORD_CNT;
    logic          WORD_VLD;
    logic          WORD_RDY;
    logic          ERR;
    logic [1:0]    ERR_CODE;

    always #5 CLK = ~CLK;

    vs_hex_word_parser #(.DIGITS(DIGITS)) dut (
        .CLK(CLK), .RST(RST),
        .ASCII(ASCII), .ASCII_VLD(ASCII_VLD), .ASCII_RDY(ASCII_RDY),
        .WORD(WORD), .WORD_CNT(WORD_CNT), .WORD_VLD(WORD_VLD), .WORD_RDY(WORD_RDY),
        .ERR(ERR), .ERR_CODE(ERR_CODE)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model
    int         q[$];
    bit         m_hold, m_disc, m_pfx, started;
    logic [15:0] e_word;
    logic [2:0]  e_cnt;
    bit          e_vld, e_err;
    logic [1:0]  e_code;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int hexval(input logic [7:0] b);
        if (b >= "0" && b <= "9") return int'(b) - 48;
        if (b >= "A" && b <= "F") return int'(b) - 55;
        if (b >= "a" && b <= "f") return int'(b) - 87;
        return -1;
    endfunction

    task automatic m_error(input logic [1:0] code);
        e_err  = 1'b1;
        e_code = code;
        q.delete();
        m_pfx  = 1'b0;
        m_disc = 1'b1;
    endtask

    task automatic model_step(input bit p_rst, input bit p_vld, input logic [7:0] p_b, input bit p_wr);
        int v;
        bit t;
        logic [15:0] w;
        e_err  = 1'b0;
        e_code = 2'b00;
        if (p_rst) begin
            m_hold = 0; m_disc = 0; m_pfx = 0; q.delete();
            e_word = '0; e_cnt = '0; e_vld = 0;
            return;
        end
        if (m_hold) begin
            if (p_wr) begin
                m_hold = 0; e_vld = 0; q.delete();
            end
            return;
        end
        if (!p_vld) return;
        v = hexval(p_b);
        t = (p_b == CR) || (p_b == LF) || (p_b == SP);
        if (m_disc) begin
            if (t) m_disc = 0;
            return;
        end
        if (q.size() == 0 && !m_pfx) begin
            if (v >= 0) q.push_back(v);
            else if (!t) m_error(2'b01);
        end else if (v >= 0) begin
            if (q.size() == DIGITS) m_error(2'b10);
            else q.push_back(v);
        end else if (t) begin
            if (q.size() == 0) begin
                e_err = 1'b1; e_code = 2'b11; m_pfx = 0;
            end else begin
                w = '0;
                foreach (q[i]) w = w * 16 + 16'(q[i]);
                e_word = w;
                e_cnt  = 3'(q.size());
                e_vld  = 1; m_hold = 1; m_pfx = 0;
            end
        end else if (PFX && (p_b == "x" || p_b == "X") && !m_pfx && q.size() == 1 && q[0] == 0) begin
            q.delete();
            m_pfx = 1;
        end else begin
            m_error(2'b01);
        end
    endtask

    // One clock cycle: inputs are already driven; compare after the edge.
    task automatic tick();
        bit p_rst, p_vld, p_wr;
        logic [7:0] p_b;
        p_rst = RST; p_vld = ASCII_VLD; p_wr = WORD_RDY; p_b = ASCII;
        if (started) chk("ascii_rdy", ASCII_RDY, !m_hold);
        @(posedge CLK);
        @(negedge CLK);
        model_step(p_rst, p_vld, p_b, p_wr);
        started = 1;
        chk("err", ERR, e_err);
        chk("err_code", ERR_CODE, e_code);
        chk("word_vld", WORD_VLD, e_vld);
        chk("word", WORD, e_word);
        chk("word_cnt", WORD_CNT, e_cnt);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        bit acc;
        int n;
        n = 0;
        ASCII = b;
        ASCII_VLD = 1'b1;
        do begin
            if (rnd) WORD_RDY = 1'($urandom_range(0, 1));
            acc = !m_hold && !RST;
            tick();
            n++;
        end while (!acc && n < 64);
        ASCII_VLD = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout byte=%0h not accepted within 64 cycles", b);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b0);
    endtask

    logic [7:0] alphabet [0:29];

    initial begin
        started = 0; m_hold = 0; m_disc = 0; m_pfx = 0;
        e_word = '0; e_cnt = '0; e_vld = 0; e_err = 0; e_code = 0;

        // Reset with a byte offered: it must be ignored.
        RST = 1; ASCII = "5"; ASCII_VLD = 1; WORD_RDY = 0;
        repeat (3) tick();
        RST = 0; ASCII_VLD = 0;
        tick();
        chk("rst_rdy", ASCII_RDY, 1);
        chk("rst_word", WORD, 16'h0000);
        chk("rst_cnt", WORD_CNT, 3'd0);

        // "1A3f\r" with consumer ready: word valid for exactly one cycle.
        WORD_RDY = 1;
        send_str("1A3f");
        send_byte(CR, 0);
        chk("t1_word", WORD, 16'h1A3F);
        chk("t1_cnt", WORD_CNT, 3'd4);
        chk("t1_vld", WORD_VLD, 1);
        tick();
        chk("t1_vld_drop", WORD_VLD, 0);

        // "7 " held for five cycles, then "2\n" offered during the handshake.
        WORD_RDY = 0;
        send_str("7");
        send_byte(SP, 0);
        repeat (5) begin
            tick();
            chk("t2_hold_word", WORD, 16'h0007);
            chk("t2_hold_rdy", ASCII_RDY, 0);
        end
        WORD_RDY = 1;
        send_str("2");
        send_byte(LF, 0);
        chk("t2_word2", WORD, 16'h0002);
        tick();

        // Invalid character inside a word.
        send_str("12G");
        chk("t3_err", ERR, 1);
        chk("t3_code", ERR_CODE, 2'b01);
        send_str("4");
        send_byte(CR, 0);
        chk("t3_novld", WORD_VLD, 0);
        send_str("5");
        send_byte(CR, 0);
        chk("t3_word", WORD, 16'h0005);
        tick();

        // Overflow on the fifth digit.
        send_str("ABCDE");
        chk("t4_code", ERR_CODE, 2'b10);
        send_byte(CR, 0);
        chk("t4_novld", WORD_VLD, 0);
        send_str("9");
        send_byte(CR, 0);
        chk("t4_idle_word", WORD, 16'h0009);
        tick();

        // Bare terminators, then reset mid-word.
        send_byte(CR, 0); send_byte(LF, 0); send_byte(SP, 0); send_byte(SP, 0);
        chk("t5_noerr", ERR, 0);
        send_str("AB");
        RST = 1;
        tick();
        RST = 0;
        send_str("C");
        send_byte(CR, 0);
        chk("t5_word", WORD, 16'h000C);
        chk("t5_cnt", WORD_CNT, 3'd1);
        tick();

        // Hex prefix handling.
        send_str("0x");
`ifdef VS_HEX_PREFIX_EN
        chk("t6_pfx_noerr", ERR, 0);
        send_str("BEEF");
        send_byte(CR, 0);
        chk("t6_word", WORD, 16'hBEEF);
        chk("t6_cnt", WORD_CNT, 3'd4);
        tick();
        send_str("0x");
        send_byte(CR, 0);
        chk("t6_empty_code", ERR_CODE, 2'b11);
        chk("t6_empty_novld", WORD_VLD, 0);
`else
        chk("t6_x_code", ERR_CODE, 2'b01);
        send_str("BEEF");
        send_byte(CR, 0);
        chk("t6_x_novld", WORD_VLD, 0);
`endif
        tick();

        // Random stream with random consumer backpressure and rare resets.
        for (int i = 0; i < 22; i++) begin
            string s;
            s = "0123456789abcdefABCDEF00001111";
            alphabet[i] = s[i];
        end
        alphabet[22] = "x"; alphabet[23] = "X"; alphabet[24] = "G";
        alphabet[25] = "#"; alphabet[26] = CR;  alphabet[27] = LF;
        alphabet[28] = SP;  alphabet[29] = CR;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 60) == 0) begin
                RST = 1;
                tick();
                RST = 0;
            end
            send_byte(alphabet[$urandom_range(0, 29)], 1'b1);
        end
        WORD_RDY = 1;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
